approx_err_monitor: RTL and testbench

- Streaming error-metric engine for approximate-adder evaluation; replaces offline testbench bookkeeping with synthesizable accumulation.
- Each valid sample supplies operands A, B and the approximate sum from the adder under test. The block computes the exact sum internally.
- Accumulates sample count, erroneous-sample count, sum of absolute error (SAE), sum of squared error (SSE) and max absolute error.
- Sits beside any WIDTH-bit adder under test in an FPGA or emulation harness; MAE/MSE are derived by the host as SAE/n and SSE/n.

---
 rtl/approx_eval_pkg.sv | 40 ++++
 rtl/approx_err_acc.sv | 66 ++++++
 rtl/approx_err_monitor.sv | 93 +++++++++
 tb/tb_approx_err_monitor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/approx_eval_pkg.sv
// Shared constants, saturating-add helper and statistics bundle for approximate-adder error evaluation.
// Pure package: no latency, no flow control.
package approx_eval_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SAE_W = 64;
   localparam int DEF_SSE_W = 96;
   localparam int DEF_CNT_W = 32;
   // Widest accumulator the helper can clamp; every accumulator width must stay at or below this.
   localparam int ACC_MAX_W = 128;

   typedef struct packed {
      logic                 ovf;
      logic [ACC_MAX_W-1:0] sum;
   } sat_res_t;

   typedef struct packed {
      logic [ACC_MAX_W-1:0] sample_cnt;
      logic [ACC_MAX_W-1:0] err_cnt;
      logic [ACC_MAX_W-1:0] sae;
      logic [ACC_MAX_W-1:0] sse;
      logic [ACC_MAX_W-1:0] max_ae;
      logic                 sat;
   } stats_t;

   // Unsigned add clamped to a w-bit all-ones ceiling; ovf flags that the clamp engaged.
   function automatic sat_res_t sat_add(input logic [ACC_MAX_W-1:0] a,
                                        input logic [ACC_MAX_W-1:0] b,
                                        input int                   w);
      sat_res_t           r;
      logic [ACC_MAX_W:0] full;
      logic [ACC_MAX_W:0] lim;
      full  = {1'b0, a} + {1'b0, b};
      lim   = ({{ACC_MAX_W{1'b0}}, 1'b1} << w) - {{ACC_MAX_W{1'b0}}, 1'b1};
      r.ovf = (full > lim);
      r.sum = r.ovf ? lim[ACC_MAX_W-1:0] : full[ACC_MAX_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/approx_err_acc.sv
// Final stage: saturating sample/error counters, SAE/SSE accumulators, max tracking and sticky sat.
// One-cycle update from the S2 sample; clr discards the sample present in the same cycle; no backpressure.
module approx_err_acc
   import approx_eval_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SAE_W = DEF_SAE_W,
   parameter int SSE_W = DEF_SSE_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 clr,
   input  logic                 v2,
   input  logic [WIDTH+1:0]     ae,
   input  logic [2*WIDTH+3:0]   ae_sq,
   output logic [CNT_W-1:0]     sample_cnt,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [SAE_W-1:0]     sae,
   output logic [SSE_W-1:0]     sse,
   output logic [WIDTH+1:0]     max_ae,
   output logic                 sat
);

   stats_t   nxt;
   sat_res_t r_cnt, r_err, r_sae, r_sse;
   logic     unused_hi;

   always_comb begin
      nxt        = '0;
      r_cnt      = sat_add(ACC_MAX_W'(sample_cnt), ACC_MAX_W'(1), CNT_W);
      r_err      = sat_add(ACC_MAX_W'(err_cnt), ACC_MAX_W'(ae != '0), CNT_W);
      r_sae      = sat_add(ACC_MAX_W'(sae), ACC_MAX_W'(ae), SAE_W);
      r_sse      = sat_add(ACC_MAX_W'(sse), ACC_MAX_W'(ae_sq), SSE_W);
      nxt.sample_cnt = r_cnt.sum;
      nxt.err_cnt    = r_err.sum;
      nxt.sae        = r_sae.sum;
      nxt.sse        = r_sse.sum;
      nxt.max_ae     = (ae > max_ae) ? ACC_MAX_W'(ae) : ACC_MAX_W'(max_ae);
      nxt.sat        = sat | r_cnt.ovf | r_err.ovf | r_sae.ovf | r_sse.ovf;
   end

   // Bits above each register width are zero by construction of the clamp.
   assign unused_hi = ^{nxt.sample_cnt[ACC_MAX_W-1:CNT_W], nxt.err_cnt[ACC_MAX_W-1:CNT_W],
                        nxt.sae[ACC_MAX_W-1:SAE_W], nxt.sse[ACC_MAX_W-1:SSE_W],
                        nxt.max_ae[ACC_MAX_W-1:WIDTH+2]};

   always_ff @(posedge Clk) begin
      if (Rst || clr) begin
         sample_cnt <= '0;
         err_cnt    <= '0;
         sae        <= '0;
         sse        <= '0;
         max_ae     <= '0;
         sat        <= 1'b0;
      end else if (v2) begin
         sample_cnt <= nxt.sample_cnt[CNT_W-1:0];
         err_cnt    <= nxt.err_cnt[CNT_W-1:0];
         sae        <= nxt.sae[SAE_W-1:0];
         sse        <= nxt.sse[SSE_W-1:0];
         max_ae     <= nxt.max_ae[WIDTH+1:0];
         sat        <= nxt.sat;
      end
   end

endmodule

// File: rtl/approx_err_monitor.sv
// Streaming error-metric engine for an approximate adder: per-sample |appx - exact| plus running statistics.
// ae_out 2 cycles, statistics 3 cycles after in_valid; one sample per cycle, no backpressure.
module approx_err_monitor
   import approx_eval_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int SIGNED = 1,
   parameter int SAE_W  = DEF_SAE_W,
   parameter int SSE_W  = DEF_SSE_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 clr,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     data_A,
   input  logic [WIDTH-1:0]     data_B,
   input  logic [WIDTH:0]       appx_sum,
   output logic                 ae_valid,
   output logic [WIDTH+1:0]     ae_out,
   output logic [CNT_W-1:0]     sample_cnt,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [SAE_W-1:0]     sae,
   output logic [SSE_W-1:0]     sse,
   output logic [WIDTH+1:0]     max_ae,
   output logic                 sat,
   output logic                 busy
);

   localparam int AE_W = WIDTH + 2;
   localparam int SQ_W = 2 * WIDTH + 4;

   logic [AE_W-1:0] a_x, b_x, s_x, diff, ae_c;
   logic [AE_W-1:0] ae1, ae2;
   logic [SQ_W-1:0] sq2;
   logic            v1, v2;

   // Working in WIDTH+2 bits keeps exact and diff free of overflow for both signedness modes.
   always_comb begin
      if (SIGNED != 0) begin
         a_x = {{2{data_A[WIDTH-1]}}, data_A};
         b_x = {{2{data_B[WIDTH-1]}}, data_B};
         s_x = {appx_sum[WIDTH], appx_sum};
      end else begin
         a_x = {2'b00, data_A};
         b_x = {2'b00, data_B};
         s_x = {1'b0, appx_sum};
      end
      diff = s_x - (a_x + b_x);
      ae_c = diff[AE_W-1] ? ({AE_W{1'b0}} - diff) : diff;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         v1  <= 1'b0;
         v2  <= 1'b0;
         ae1 <= '0;
         ae2 <= '0;
         sq2 <= '0;
      end else begin
         v1  <= in_valid & ~clr;
         v2  <= v1 & ~clr;
         ae1 <= ae_c;
         ae2 <= ae1;
         sq2 <= SQ_W'(ae1) * SQ_W'(ae1);
      end
   end

   assign ae_valid = v2;
   assign ae_out   = ae2;
   assign busy     = v1 | v2;

   approx_err_acc #(
      .WIDTH (WIDTH),
      .SAE_W (SAE_W),
      .SSE_W (SSE_W),
      .CNT_W (CNT_W)
   ) u_acc (
      .Clk        (Clk),
      .Rst        (Rst),
      .clr        (clr),
      .v2         (v2),
      .ae         (ae2),
      .ae_sq      (sq2),
      .sample_cnt (sample_cnt),
      .err_cnt    (err_cnt),
      .sae        (sae),
      .sse        (sse),
      .max_ae     (max_ae),
      .sat        (sat)
   );

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench: three WIDTH=8 instances (unsigned, signed, 3-bit counters) share one stimulus stream.
module tb_approx_err_monitor;

   logic       Clk = 1'b0;
   logic       Rst, clr, in_valid;
   logic [7:0] data_A, data_B;
   logic [8:0] appx_sum;

   logic        ae_valid_u, sat_u, busy_u;
   logic [9:0]  ae_out_u, max_ae_u;
   logic [31:0] sample_cnt_u, err_cnt_u;
   logic [63:0] sae_u;
   logic [95:0] sse_u;

   logic        ae_valid_s, sat_s, busy_s;
   logic [9:0]  ae_out_s, max_ae_s;
   logic [31:0] sample_cnt_s, err_cnt_s;
   logic [63:0] sae_s;
   logic [95:0] sse_s;

   logic        ae_valid_t, sat_t, busy_t;
   logic [9:0]  ae_out_t, max_ae_t;
   logic [2:0]  sample_cnt_t, err_cnt_t;
   logic [63:0] sae_t;
   logic [95:0] sse_t;

   int n_cmp = 0;
   int n_bad = 0;
   logic [9:0] ae_log[$];

   always #5 Clk = ~Clk;

   approx_err_monitor #(.WIDTH(8), .SIGNED(0)) u_uns (
      .Clk(Clk), .Rst(Rst), .clr(clr), .in_valid(in_valid),
      .data_A(data_A), .data_B(data_B), .appx_sum(appx_sum),
      .ae_valid(ae_valid_u), .ae_out(ae_out_u), .sample_cnt(sample_cnt_u), .err_cnt(err_cnt_u),
      .sae(sae_u), .sse(sse_u), .max_ae(max_ae_u), .sat(sat_u), .busy(busy_u));

   approx_err_monitor #(.WIDTH(8), .SIGNED(1)) u_sgn (
      .Clk(Clk), .Rst(Rst), .clr(clr), .in_valid(in_valid),
      .data_A(data_A), .data_B(data_B), .appx_sum(appx_sum),
      .ae_valid(ae_valid_s), .ae_out(ae_out_s), .sample_cnt(sample_cnt_s), .err_cnt(err_cnt_s),
      .sae(sae_s), .sse(sse_s), .max_ae(max_ae_s), .sat(sat_s), .busy(busy_s));

   approx_err_monitor #(.WIDTH(8), .SIGNED(0), .CNT_W(3)) u_sat (
      .Clk(Clk), .Rst(Rst), .clr(clr), .in_valid(in_valid),
      .data_A(data_A), .data_B(data_B), .appx_sum(appx_sum),
      .ae_valid(ae_valid_t), .ae_out(ae_out_t), .sample_cnt(sample_cnt_t), .err_cnt(err_cnt_t),
      .sae(sae_t), .sse(sse_t), .max_ae(max_ae_t), .sat(sat_t), .busy(busy_t));

   always @(negedge Clk) if (ae_valid_u) ae_log.push_back(ae_out_u);

   task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] s);
      data_A   = a;
      data_B   = b;
      appx_sum = s;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] ra, rb;
      Rst = 1'b1; clr = 1'b1; in_valid = 1'b1;
      data_A = 8'd9; data_B = 8'd9; appx_sum = 9'd3;
      step(); step();
      Rst = 1'b0; clr = 1'b0; in_valid = 1'b0;
      chk_eq("rst_cnt",   sample_cnt_u, 0);
      chk_eq("rst_err",   err_cnt_u,    0);
      chk_eq("rst_sae",   sae_u,        0);
      chk_eq("rst_sse",   sse_u,        0);
      chk_eq("rst_max",   max_ae_u,     0);
      chk_eq("rst_sat",   sat_u,        0);
      chk_eq("rst_busy",  busy_u,       0);
      chk_eq("rst_aevld", ae_valid_u,   0);
      chk_eq("rst_aeout", ae_out_u,     0);

      // Exact adder: 100 random error-free samples.
      for (int i = 0; i < 100; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         send(ra, rb, {1'b0, ra} + {1'b0, rb});
      end
      repeat (3) step();
      chk_eq("exact_cnt", sample_cnt_u, 100);
      chk_eq("exact_err", err_cnt_u,    0);
      chk_eq("exact_sae", sae_u,        0);
      chk_eq("exact_sse", sse_u,        0);
      chk_eq("exact_max", max_ae_u,     0);
      chk_eq("exact_sat", sat_u,        0);

      // Fixed-error samples, back to back.
      do_clr();
      chk_eq("clr_cnt", sample_cnt_u, 0);
      ae_log.delete();
      send(8'd10, 8'd20, 9'd26);
      send(8'd200, 8'd100, 9'd300);
      send(8'd5, 8'd5, 9'd14);
      repeat (3) step();
      chk_eq("fix_nae", ae_log.size(), 3);
      if (ae_log.size() == 3) begin
         chk_eq("fix_ae0", ae_log[0], 4);
         chk_eq("fix_ae1", ae_log[1], 0);
         chk_eq("fix_ae2", ae_log[2], 4);
      end
      chk_eq("fix_sae", sae_u,        8);
      chk_eq("fix_sse", sse_u,        32);
      chk_eq("fix_err", err_cnt_u,    2);
      chk_eq("fix_max", max_ae_u,     4);
      chk_eq("fix_cnt", sample_cnt_u, 3);

      // Unsigned extremes: largest error in each direction.
      do_clr();
      send(8'd255, 8'd255, 9'd0);
      send(8'd0, 8'd0, 9'd511);
      repeat (3) step();
      chk_eq("uext_max", max_ae_u, 511);
      chk_eq("uext_sae", sae_u,    1021);
      chk_eq("uext_sse", sse_u,    521221);
      chk_eq("uext_err", err_cnt_u, 2);

      // Signed worst case: -128 + -128 = -256 against +255.
      do_clr();
      send(8'h80, 8'h80, 9'h0FF);
      step();
      chk_eq("sgn_aevld", ae_valid_s, 1);
      chk_eq("sgn_ae",    ae_out_s,   511);
      step();
      chk_eq("sgn_max", max_ae_s,   511);
      chk_eq("sgn_sae", sae_s,      511);
      chk_eq("sgn_sse", sse_s,      261121);
      chk_eq("sgn_cnt", sample_cnt_s, 1);

      // Latency: in_valid on cycles 0..4.
      do_clr();
      step();
      for (int t = 0; t < 10; t++) begin
         in_valid = (t <= 4);
         data_A   = 8'(t);
         data_B   = 8'(t);
         appx_sum = 9'(2 * t);
         chk_eq($sformatf("lat_aevld_c%0d", t), ae_valid_u, (t >= 2 && t <= 6));
         chk_eq($sformatf("lat_busy_c%0d", t),  busy_u,     (t >= 1 && t <= 6));
         chk_eq($sformatf("lat_cnt_c%0d", t),   sample_cnt_u, (t < 3) ? 0 : ((t - 2 > 5) ? 5 : t - 2));
         step();
      end
      in_valid = 1'b0;

      // clr mid-stream on cycle 3 of samples 0..5.
      do_clr();
      for (int t = 0; t < 6; t++) begin
         clr      = (t == 3);
         in_valid = 1'b1;
         data_A   = 8'd10;
         data_B   = 8'd20;
         appx_sum = (t == 4) ? 9'd31 : ((t == 5) ? 9'd32 : 9'd37);
         step();
      end
      clr = 1'b0; in_valid = 1'b0;
      repeat (3) step();
      chk_eq("mclr_cnt", sample_cnt_u, 2);
      chk_eq("mclr_err", err_cnt_u,    2);
      chk_eq("mclr_sae", sae_u,        3);
      chk_eq("mclr_sse", sse_u,        5);
      chk_eq("mclr_max", max_ae_u,     2);
      chk_eq("mclr_sat", sat_u,        0);

      // Saturation with 3-bit counters.
      do_clr();
      for (int i = 0; i < 7; i++) send(8'(i), 8'd1, 9'(i + 1));
      repeat (3) step();
      chk_eq("sat7_cnt", sample_cnt_t, 7);
      chk_eq("sat7_sat", sat_t,        0);
      send(8'd3, 8'd3, 9'd6);
      repeat (3) step();
      chk_eq("sat8_cnt", sample_cnt_t, 7);
      chk_eq("sat8_sat", sat_t,        1);
      send(8'd4, 8'd4, 9'd8);
      repeat (3) step();
      chk_eq("sat9_cnt", sample_cnt_t, 7);
      chk_eq("sat9_sat", sat_t,        1);
      chk_eq("sat9_err", err_cnt_t,    0);
      send(8'd1, 8'd1, 9'd2);
      Rst = 1'b1; in_valid = 1'b1;
      step();
      Rst = 1'b0; in_valid = 1'b0;
      chk_eq("srst_cnt",  sample_cnt_t, 0);
      chk_eq("srst_sat",  sat_t,        0);
      chk_eq("srst_sae",  sae_t,        0);
      chk_eq("srst_busy", busy_t,       0);
      chk_eq("srst_vld",  ae_valid_t,   0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
